// File: rtl/efuse_wb_autoload_if.sv
// rtl/efuse_wb_autoload_if.sv - Wishbone master bus bundle for the eFuse shadow autoloader
// Signals:
//   wbm_adr_o  [31:0]  byte address            (master -> slave)
//   wbm_dat_o  [31:0]  write data, always 0    (master -> slave)
//   wbm_we_o           write enable, always 0  (master -> slave)
//   wbm_sel_o  [3:0]   byte selects, always F  (master -> slave)
//   wbm_stb_o          strobe                  (master -> slave)
//   wbm_cyc_o          cycle                   (master -> slave)
//   wbm_dat_i  [31:0]  read data               (slave -> master)
//   wbm_ack_i          acknowledge             (slave -> master)
interface efuse_wb_autoload_if;
    logic [31:0] wbm_adr_o;
    logic [31:0] wbm_dat_o;
    logic        wbm_we_o;
    logic [3:0]  wbm_sel_o;
    logic        wbm_stb_o;
    logic        wbm_cyc_o;
    logic [31:0] wbm_dat_i;
    logic        wbm_ack_i;

    modport master (
        output wbm_adr_o, wbm_dat_o, wbm_we_o, wbm_sel_o, wbm_stb_o, wbm_cyc_o,
        input  wbm_dat_i, wbm_ack_i
    );

    modport slave (
        input  wbm_adr_o, wbm_dat_o, wbm_we_o, wbm_sel_o, wbm_stb_o, wbm_cyc_o,
        output wbm_dat_i, wbm_ack_i
    );
endinterface

// File: rtl/efuse_wb_autoload.sv
// rtl/efuse_wb_autoload.sv - boot-time Wishbone reader that shadows eFuse words into registers
// Ports:
//   wb_clk_i      clock
//   wb_rst_ni     asynchronous active-low reset
//   start_i       reload request pulse, ignored while busy_o=1
//   wb            efuse_wb_autoload_if.master, read-only Wishbone master
//   shadow_o      NUM_WORDS*32 flat shadow bank, word i at [32*i+31:32*i]
//   busy_o        load sequence in progress
//   valid_o       all words loaded and checksum (if enabled) good
//   error_o       load aborted by ack timeout
//   check_err_o   checksum mismatch
// Build option: EFUSE_AUTOLOAD_CHECK_EN enables the XOR checksum on the last word.
module efuse_wb_autoload #(
    parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
    parameter int          NUM_WORDS      = 8,
    parameter int          TIMEOUT_CYCLES = 255
) (
    input  logic                      wb_clk_i,
    input  logic                      wb_rst_ni,
    input  logic                      start_i,
    efuse_wb_autoload_if.master       wb,
    output logic [NUM_WORDS*32-1:0]   shadow_o,
    output logic                      busy_o,
    output logic                      valid_o,
    output logic                      error_o,
    output logic                      check_err_o
);

    localparam int IW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [IW-1:0] I_LAST = IW'(NUM_WORDS - 1);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_LATCH,
        S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic          auto_q, auto_d;
    logic          valid_q, valid_d;
    logic          error_q, error_d;
    logic          chk_q, chk_d;
    logic          capture;
    logic          begin_load;
    logic          sum_bad;
    logic [31:0]   shadow_q [NUM_WORDS];

`ifdef EFUSE_AUTOLOAD_CHECK_EN
    // Evaluated in LATCH of the last word, when the whole bank has been captured.
    logic [31:0] sum_acc;
    always_comb begin
        sum_acc = '0;
        for (int i = 0; i < NUM_WORDS - 1; i++) begin
            sum_acc = sum_acc ^ shadow_q[i];
        end
        sum_bad = (NUM_WORDS > 1) && (sum_acc != shadow_q[NUM_WORDS-1]);
    end
`else
    assign sum_bad = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        tcnt_d     = tcnt_q;
        auto_d     = auto_q;
        valid_d    = valid_q;
        error_d    = error_q;
        chk_d      = chk_q;
        capture    = 1'b0;
        begin_load = 1'b0;

        case (state_q)
            S_IDLE: begin
                // auto_q makes the first cycle after reset release start a load.
                if (auto_q || start_i) begin
                    begin_load = 1'b1;
                end
            end
            S_REQ: begin
                // An ack on the limit cycle still wins over the timeout.
                if (wb.wbm_ack_i) begin
                    capture = 1'b1;
                    state_d = S_LATCH;
                end else if (tcnt_q == T_LAST) begin
                    error_d = 1'b1;
                    state_d = S_DONE;
                end else begin
                    tcnt_d = tcnt_q + TW'(1);
                end
            end
            S_LATCH: begin
                if (idx_q != I_LAST) begin
                    idx_d   = idx_q + IW'(1);
                    tcnt_d  = '0;
                    state_d = S_REQ;
                end else begin
                    chk_d   = sum_bad;
                    valid_d = !sum_bad;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (start_i) begin
                    begin_load = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (begin_load) begin
            state_d = S_REQ;
            idx_d   = '0;
            tcnt_d  = '0;
            auto_d  = 1'b0;
            valid_d = 1'b0;
            error_d = 1'b0;
            chk_d   = 1'b0;
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            tcnt_q  <= '0;
            auto_q  <= 1'b1;
            valid_q <= 1'b0;
            error_q <= 1'b0;
            chk_q   <= 1'b0;
            for (int i = 0; i < NUM_WORDS; i++) begin
                shadow_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            tcnt_q  <= tcnt_d;
            auto_q  <= auto_d;
            valid_q <= valid_d;
            error_q <= error_d;
            chk_q   <= chk_d;
            if (capture) begin
                shadow_q[idx_q] <= wb.wbm_dat_i;
            end
        end
    end

    // Bus controls come straight from the state register, so reset drops them
    // asynchronously and the address stays stable for the whole request.
    assign wb.wbm_stb_o = (state_q == S_REQ);
    assign wb.wbm_cyc_o = (state_q == S_REQ);
    assign wb.wbm_adr_o = BASE_ADDR + (32'(idx_q) << 2);
    assign wb.wbm_dat_o = 32'h0000_0000;
    assign wb.wbm_we_o  = 1'b0;
    assign wb.wbm_sel_o = 4'hF;

    assign busy_o      = (state_q == S_REQ) || (state_q == S_LATCH);
    assign valid_o     = valid_q;
    assign error_o     = error_q;
    assign check_err_o = chk_q;

    for (genvar g = 0; g < NUM_WORDS; g++) begin : g_shadow
        assign shadow_o[32*g +: 32] = shadow_q[g];
    end

endmodule
